// File: rtl/xpb_pkg.sv
// Shared definitions for the run-time programmable xpb reduction-constant tables.
package xpb_pkg;

  // Default geometry: 5-bit digits index 32-entry tables of 1024-bit words.
  localparam int DEF_IDX_W  = 5;
  localparam int DEF_DATA_W = 1024;
  localparam int DEPTH      = 2 ** DEF_IDX_W;

  typedef logic [DEF_DATA_W-1:0] xpb_word_t;

  // CLEAR zeroes every table after reset; RUN serves lookups and config writes.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } xpb_state_e;

endpackage

// File: rtl/xpb_lut_ram.sv
// One DEPTH x DATA_W table: a single write port and one registered,
// read-first read port. Entry 0 is hard-wired to read zero, so the
// digit-0 term of the reduction never needs a stored word.
module xpb_lut_ram
  import xpb_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];
  logic [DATA_W-1:0] rdata_reg;

  // Storage write; entry 0 is never written since its read is forced to zero.
  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-edge write is not yet visible, giving read-first.
  // The register only loads on a read so the output holds between lookups.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= (raddr == '0) ? '0 : mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/xpb_lut_bank.sv
// Bank of NUM_LUT programmable x*2^k mod p tables looked up in parallel.
// After reset the tables are zeroed one entry per cycle; lookups and
// config writes are only serviced once that sweep has finished.
module xpb_lut_bank
  import xpb_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_LUT = 4,
  parameter int RD_LAT  = 1,
  localparam int LUT_W  = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [LUT_W-1:0]          cfg_lut,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [DATA_W-1:0]         cfg_data,
  input  logic                      rd_valid,
  input  logic [NUM_LUT*IDX_W-1:0]  rd_idx,
  output logic [NUM_LUT*DATA_W-1:0] rd_data,
  output logic                      rd_data_valid,
  output logic                      ready
);

  xpb_state_e                state_reg;
  xpb_state_e                state_next;
  logic [IDX_W-1:0]          clr_cnt_reg;
  logic                      clearing;
  logic                      running;
  logic                      rd_fire;
  logic [NUM_LUT*DATA_W-1:0] ram_rdata;
  logic [RD_LAT-1:0]         vld_reg;

  // State register; reset from any state restarts the clearing sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Clear counter walks every entry once, wrapping to 0 as RUN is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + 1'b1;
    end
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:   if (clr_cnt_reg == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // State decode; ready/cfg_ready come straight from the state register.
  always_comb begin
    clearing = (state_reg == CLEAR);
    running  = (state_reg == RUN);
  end

  assign ready     = running;
  assign cfg_ready = running;
  assign rd_fire   = rd_valid & running;

  // One table per LUT; clearing writes zero to all tables at once, otherwise
  // an accepted config write is steered to the table selected by cfg_lut.
  for (genvar gi = 0; gi < NUM_LUT; gi++) begin : g_lut
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;

    // Write-port mux between the clear sweep and the config port.
    always_comb begin
      we    = clearing | (cfg_valid & running & (cfg_lut == LUT_W'(gi)));
      waddr = clearing ? clr_cnt_reg : cfg_idx;
      wdata = clearing ? '0 : cfg_data;
    end

    xpb_lut_ram #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (rd_fire),
      .raddr (rd_idx[gi*IDX_W +: IDX_W]),
      .rdata (ram_rdata[gi*DATA_W +: DATA_W])
    );
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [NUM_LUT*DATA_W-1:0] out_reg;

    // Two-stage valid pipeline matching the extra output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_reg <= '0;
      end else begin
        vld_reg <= {vld_reg[0], rd_fire};
      end
    end

    // Output register loads only on a live response so rd_data holds otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        out_reg <= '0;
      end else if (vld_reg[0]) begin
        out_reg <= ram_rdata;
      end
    end

    assign rd_data = out_reg;
  end else begin : g_lat1
    // Single-stage valid pipeline aligned with the RAM read register.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_reg <= '0;
      end else begin
        vld_reg <= rd_fire;
      end
    end

    assign rd_data = ram_rdata;
  end

  assign rd_data_valid = vld_reg[RD_LAT-1];

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Self-checking bench for xpb_lut_bank: a reference table model feeds a
// queue of expected responses, a monitor pops and compares them, and each
// scenario task adds its own timing and boundary checks.
module tb_xpb_lut_bank;
  import xpb_pkg::*;

  localparam int IDX_W   = 5;
  localparam int DATA_W  = 1024;
  localparam int NUM_LUT = 4;
  localparam int RD_LAT  = 1;
  localparam int LUT_W   = 2;
  localparam int NDEPTH  = 32;

  typedef logic [NUM_LUT*DATA_W-1:0] bus_t;
  typedef logic [NUM_LUT*IDX_W-1:0]  idx_bus_t;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      cfg_valid = 1'b0;
  logic                      cfg_ready;
  logic [LUT_W-1:0]          cfg_lut = '0;
  logic [IDX_W-1:0]          cfg_idx = '0;
  logic [DATA_W-1:0]         cfg_data = '0;
  logic                      rd_valid = 1'b0;
  idx_bus_t                  rd_idx = '0;
  bus_t                      rd_data;
  logic                      rd_data_valid;
  logic                      ready;

  xpb_word_t model [NUM_LUT][NDEPTH];
  bus_t      exp_q [$];
  bus_t      mon_exp;
  int        n_cmp = 0;
  int        n_bad = 0;
  int        n_rsp = 0;

  xpb_lut_bank #(
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W),
    .NUM_LUT (NUM_LUT),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_lut       (cfg_lut),
    .cfg_idx       (cfg_idx),
    .cfg_data      (cfg_data),
    .rd_valid      (rd_valid),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every response must match the oldest expected entry.
  always @(posedge clk) begin
    #2;
    if (rd_data_valid === 1'b1) begin
      n_cmp++;
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: rd_data_valid=1 required no response");
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_bad++;
          for (int l = 0; l < NUM_LUT; l++) begin
            for (int c = 0; c < DATA_W / 64; c++) begin
              if (rd_data[l*DATA_W + c*64 +: 64] !== mon_exp[l*DATA_W + c*64 +: 64])
                $display("FAIL rsp_data %0d: table %0d chunk %0d got %h required %h", n_rsp, l, c,
                         rd_data[l*DATA_W + c*64 +: 64], mon_exp[l*DATA_W + c*64 +: 64]);
            end
          end
        end else begin
          $display("rsp %0d ok", n_rsp);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic xpb_word_t rand_word();
    xpb_word_t w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Drive one cycle of stimulus at the falling edge and update the model.
  task automatic step(input logic rv, input idx_bus_t idx, input logic cv,
                      input logic [LUT_W-1:0] cl, input logic [IDX_W-1:0] ci,
                      input xpb_word_t cd);
    bus_t e;
    @(negedge clk);
    rd_valid  = rv;
    rd_idx    = idx;
    cfg_valid = cv;
    cfg_lut   = cl;
    cfg_idx   = ci;
    cfg_data  = cd;
    if (rv && ready === 1'b1 && !reset) begin
      for (int i = 0; i < NUM_LUT; i++) e[i*DATA_W +: DATA_W] = model[i][idx[i*IDX_W +: IDX_W]];
      exp_q.push_back(e);
      $display("issue lookup idx=%h", idx);
    end
    if (cv && cfg_ready === 1'b1 && !reset && ci != '0) begin
      model[cl][ci] = cd;
      $display("issue write table=%0d idx=%0d", cl, ci);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // Assert reset at a falling edge, flushing in-flight expectations and the model.
  task automatic assert_reset();
    @(negedge clk);
    reset     = 1'b1;
    rd_valid  = 1'b1;
    cfg_valid = 1'b0;
    exp_q.delete();
    for (int l = 0; l < NUM_LUT; l++)
      for (int i = 0; i < NDEPTH; i++) model[l][i] = '0;
  endtask

  // Count rising edges after release until ready; pokes reads and writes meanwhile.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        cyc = k;
        break;
      end
      rd_valid  = 1'b1;
      rd_idx    = (NUM_LUT*IDX_W)'($urandom);
      cfg_valid = 1'b1;
      cfg_lut   = '0;
      cfg_idx   = 5'd5;
      cfg_data  = '1;
    end
    rd_valid  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic read_all_indices();
    idx_bus_t v;
    for (int i = 0; i < NDEPTH; i++) begin
      for (int l = 0; l < NUM_LUT; l++) v[l*IDX_W +: IDX_W] = IDX_W'(i);
      step(1'b1, v, 1'b0, '0, '0, '0);
    end
    idle(RD_LAT + 1);
  endtask

  task automatic test_reset();
    int cyc;
    $display("test_reset");
    assert_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready, cfg_ready, rd_data_valid} !== 3'b000 || rd_data !== '0) begin
      n_bad++;
      $display("FAIL reset_values: ready/cfg_ready/valid=%b data_nonzero=%0d required 000 and 0",
               {ready, cfg_ready, rd_data_valid}, rd_data !== '0);
    end
    reset = 1'b0;
    wait_ready(cyc);
    n_cmp++;
    if (cyc != NDEPTH) begin
      n_bad++;
      $display("FAIL ready_latency: got %0d required %0d", cyc, NDEPTH);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_ready_run: got %b required 1", cfg_ready);
    end
  endtask

  task automatic test_all_zero();
    $display("test_all_zero");
    read_all_indices();
  endtask

  task automatic test_write_read();
    xpb_word_t v;
    v = {16{64'h5d50_3c1e_9a7b_804a}};
    $display("test_write_read");
    step(1'b0, '0, 1'b1, 2'd2, 5'd1, v);
    step(1'b1, {NUM_LUT{5'd1}}, 1'b0, '0, '0, '0);
    repeat (RD_LAT) @(posedge clk);
    #2;
    n_cmp++;
    if (rd_data_valid !== 1'b1 || rd_data[2*DATA_W +: DATA_W] !== v) begin
      n_bad++;
      $display("FAIL write_read: valid=%b slice2_low=%h required 1 and %h",
               rd_data_valid, rd_data[2*DATA_W +: 64], v[63:0]);
    end
    idle(RD_LAT + 1);
  endtask

  task automatic test_idx0();
    $display("test_idx0");
    for (int l = 0; l < NUM_LUT; l++) step(1'b0, '0, 1'b1, LUT_W'(l), 5'd0, '1);
    step(1'b1, '0, 1'b0, '0, '0, '0);
    repeat (RD_LAT) @(posedge clk);
    #2;
    n_cmp++;
    if (rd_data_valid !== 1'b1 || rd_data !== '0) begin
      n_bad++;
      $display("FAIL idx0_zero: valid=%b slice0_low=%h required 1 and 0",
               rd_data_valid, rd_data[63:0]);
    end
    idle(RD_LAT + 1);
  endtask

  task automatic test_read_first();
    xpb_word_t a;
    xpb_word_t b;
    a = rand_word();
    b = ~a;
    $display("test_read_first");
    step(1'b0, '0, 1'b1, 2'd1, 5'd7, b);
    step(1'b1, {NUM_LUT{5'd7}}, 1'b1, 2'd1, 5'd7, a);
    repeat (RD_LAT) @(posedge clk);
    #2;
    n_cmp++;
    if (rd_data[DATA_W +: DATA_W] !== b) begin
      n_bad++;
      $display("FAIL read_first_old: got %h required %h", rd_data[DATA_W +: 64], b[63:0]);
    end
    step(1'b1, {NUM_LUT{5'd7}}, 1'b0, '0, '0, '0);
    repeat (RD_LAT) @(posedge clk);
    #2;
    n_cmp++;
    if (rd_data[DATA_W +: DATA_W] !== a) begin
      n_bad++;
      $display("FAIL read_first_new: got %h required %h", rd_data[DATA_W +: 64], a[63:0]);
    end
    idle(RD_LAT + 1);
  endtask

  task automatic test_back_to_back();
    idx_bus_t v;
    $display("test_back_to_back");
    for (int k = 0; k < 40; k++) begin
      for (int l = 0; l < NUM_LUT; l++) v[l*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, NDEPTH - 1));
      step(1'b1, v, ($urandom_range(0, 1) == 1), LUT_W'($urandom_range(0, NUM_LUT - 1)),
           IDX_W'($urandom_range(0, NDEPTH - 1)), rand_word());
      if (k >= RD_LAT) begin
        n_cmp++;
        if (rd_data_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_gap: cycle %0d valid=%b required 1", k, rd_data_valid);
        end
      end
    end
    for (int j = 0; j <= RD_LAT; j++) begin
      step(1'b0, '0, 1'b0, '0, '0, '0);
      n_cmp++;
      if (rd_data_valid !== (j < RD_LAT)) begin
        n_bad++;
        $display("FAIL b2b_tail: tail %0d valid=%b required %b", j, rd_data_valid, j < RD_LAT);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int cyc;
    $display("test_reset_midflight");
    step(1'b0, '0, 1'b1, 2'd3, 5'd9, rand_word());
    step(1'b0, '0, 1'b1, 2'd0, 5'd31, rand_word());
    step(1'b1, {NUM_LUT{5'd9}}, 1'b0, '0, '0, '0);
    assert_reset();
    @(posedge clk);
    #2;
    n_cmp++;
    if (rd_data_valid !== 1'b0 || ready !== 1'b0 || rd_data !== '0) begin
      n_bad++;
      $display("FAIL reset_inflight: valid=%b ready=%b data_nonzero=%0d required 0 0 0",
               rd_data_valid, ready, rd_data !== '0);
    end
    @(negedge clk);
    reset    = 1'b0;
    rd_valid = 1'b0;
    repeat (10) @(negedge clk);
    assert_reset();
    @(negedge clk);
    reset    = 1'b0;
    rd_valid = 1'b0;
    wait_ready(cyc);
    n_cmp++;
    if (cyc != NDEPTH) begin
      n_bad++;
      $display("FAIL ready_after_midclear: got %0d required %0d", cyc, NDEPTH);
    end
    read_all_indices();
  endtask

  initial begin
    for (int l = 0; l < NUM_LUT; l++)
      for (int i = 0; i < NDEPTH; i++) model[l][i] = '0;
    test_reset();
    test_all_zero();
    test_write_read();
    test_idx0();
    test_read_first();
    test_back_to_back();
    test_reset_midflight();
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_rsp: %0d outstanding required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
